// File: rtl/cache_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_axi_bridge                                             |
// | Description : Turns whole-line dcache refill / write-back requests into    |
// |               8-beat AXI INCR bursts and returns a one-cycle grant.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cache_axi_bridge #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  // cache side
  input  logic [31:0]                 axi_addr,
  input  logic                        axi_rd_req,
  input  logic                        axi_wr_req,
  input  logic [LINE_WORDS-1:0][31:0] axi_wr_data,
  output logic                        axi_gnt,
  output logic [LINE_WORDS-1:0][31:0] axi_rd_data,
  output logic                        bus_err,
  // AXI read address
  output logic [3:0]                  arid,
  output logic [31:0]                 araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  // AXI write address
  output logic [3:0]                  awid,
  output logic [31:0]                 awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  // AXI read data
  input  logic [31:0]                 rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  // AXI write data
  output logic [31:0]                 wdata,
  output logic [3:0]                  wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  // AXI write response
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int              CNT_W       = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]      C_LEN       = 8'(LINE_WORDS - 1);
  localparam logic [2:0]      C_SIZE      = 3'b010;
  localparam logic [1:0]      C_INCR      = 2'b01;
  localparam logic [31:0]     C_LINE_MASK = 32'hFFFF_FFE0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WADDR = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_WRESP = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [31:0]                 r_addr;
  logic [LINE_WORDS-1:0][31:0] r_line;
  logic [LINE_WORDS-1:0][31:0] r_rd_data;
  logic                        r_err;
  logic                        w_err_nxt;

  logic r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready, r_gnt, r_bus_err;
  logic w_arvalid_nxt, w_awvalid_nxt, w_wvalid_nxt, w_rready_nxt, w_bready_nxt;
  logic w_gnt_nxt, w_bus_err_nxt;
  logic w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs;

  assign w_ar_hs = (r_state == S_RADDR) && r_arvalid && arready;
  assign w_aw_hs = (r_state == S_WADDR) && r_awvalid && awready;
  assign w_r_hs  = (r_state == S_RDATA) && r_rready  && rvalid;
  assign w_w_hs  = (r_state == S_WDATA) && r_wvalid  && wready;
  assign w_b_hs  = (r_state == S_WRESP) && r_bready  && bvalid;

  // State register together with the registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rready  <= 1'b0;
      r_bready  <= 1'b0;
      r_gnt     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_bready  <= w_bready_nxt;
      r_gnt     <= w_gnt_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  // Burst completion is counted in beats; rlast only feeds the error flag
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (axi_wr_req)      w_state_nxt = S_WADDR;
        else if (axi_rd_req) w_state_nxt = S_RADDR;
      end
      S_RADDR: if (w_ar_hs) w_state_nxt = S_RDATA;
      S_RDATA: if (w_r_hs && (r_cnt == C_LAST)) w_state_nxt = S_DONE;
      S_WADDR: if (w_aw_hs) w_state_nxt = S_WDATA;
      S_WDATA: if (w_w_hs && (r_cnt == C_LAST)) w_state_nxt = S_WRESP;
      S_WRESP: if (w_b_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_arvalid_nxt = (w_state_nxt == S_RADDR);
    w_awvalid_nxt = (w_state_nxt == S_WADDR);
    w_wvalid_nxt  = (w_state_nxt == S_WDATA);
    w_rready_nxt  = (w_state_nxt == S_RDATA);
    w_bready_nxt  = (w_state_nxt == S_WRESP);
    w_gnt_nxt     = (w_state_nxt == S_DONE);

    w_cnt_nxt = r_cnt;
    if ((r_state == S_RADDR) || (r_state == S_WADDR)) w_cnt_nxt = '0;
    else if (w_r_hs || w_w_hs)                        w_cnt_nxt = r_cnt + C_CNT_ONE;

    w_err_nxt = r_err;
    if (w_r_hs && ((rresp != 2'b00) || (rlast != (r_cnt == C_LAST)))) w_err_nxt = 1'b1;
    if (w_b_hs && (bresp != 2'b00))                                   w_err_nxt = 1'b1;
    if (r_state == S_DONE)                                            w_err_nxt = 1'b0;

    w_bus_err_nxt = w_gnt_nxt && w_err_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_line    <= '0;
      r_rd_data <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
      if ((r_state == S_IDLE) && (axi_wr_req || axi_rd_req))
        r_addr <= axi_addr & C_LINE_MASK;
      if ((r_state == S_IDLE) && axi_wr_req)
        r_line <= axi_wr_data;
      // The refilled line is consumed after the grant, so it only moves on R beats
      if (w_r_hs)
        r_rd_data[r_cnt] <= rdata;
    end
  end

  assign axi_gnt     = r_gnt;
  assign bus_err     = r_bus_err;
  assign axi_rd_data = r_rd_data;

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arlen   = C_LEN;
  assign arsize  = C_SIZE;
  assign arburst = C_INCR;
  assign arvalid = r_arvalid;

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = C_LEN;
  assign awsize  = C_SIZE;
  assign awburst = C_INCR;
  assign awvalid = r_awvalid;

  assign rready  = r_rready;

  assign wdata   = r_line[r_cnt];
  assign wstrb   = 4'hF;
  assign wlast   = (r_state == S_WDATA) && (r_cnt == C_LAST);
  assign wvalid  = r_wvalid;

  assign bready  = r_bready;

endmodule
`default_nettype wire
